// File: rtl/linea_pattern_tx_if.sv
// Handshake and serial-line bundle for linea_pattern_tx.
// The master drives the request side; the slave (the transmitter) drives the line and status.
interface linea_pattern_tx_if #(
  parameter int unsigned MAX_LEN = 8
) ();

  logic               start;
  logic [MAX_LEN-1:0] data;
  logic [3:0]         len;
  logic               ready;
  logic               LINEA;
  logic               bit_valid;
  logic               done;
  logic               err;
  logic [7:0]         frame_count;

  modport master (
    output start,
    output data,
    output len,
    input  ready,
    input  LINEA,
    input  bit_valid,
    input  done,
    input  err,
    input  frame_count
  );

  modport slave (
    input  start,
    input  data,
    input  len,
    output ready,
    output LINEA,
    output bit_valid,
    output done,
    output err,
    output frame_count
  );

endinterface

// File: rtl/linea_pattern_tx.sv
// Serial pattern transmitter: shifts a code word of programmable length out MSB-first on LINEA,
// then holds the idle level for GAP_CYCLES before accepting the next word.
module linea_pattern_tx #(
  parameter int unsigned MAX_LEN    = 8,
  parameter int unsigned GAP_CYCLES = 2,
  parameter logic        IDLE_LEVEL = 1'b0
) (
  input logic               clock,
  input logic               reset,
  linea_pattern_tx_if.slave bus_io
);

  localparam int unsigned CntW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned GapW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StSend,
    StGap
  } state_e;

  state_e state_q, state_d;

  logic [MAX_LEN-1:0] sreg_q, sreg_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [GapW-1:0]    gap_q, gap_d;
  logic               linea_q, linea_d;
  logic               bit_valid_q, bit_valid_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [7:0]         fcount_q, fcount_d;
  logic               ready;

  logic            len_legal;
  logic            accept;
  logic            reject;
  logic [CntW-1:0] len_m1;
  logic [CntW-1:0] cnt_dec;
  logic [GapW-1:0] gap_load;

  // Upper bits of len beyond MAX_LEN make the request illegal, as does len == 0.
  assign len_legal = (bus_io.len != 4'd0) && (32'(bus_io.len) <= MAX_LEN);
  assign accept    = (state_q == StIdle) && bus_io.start && len_legal;
  assign reject    = (state_q == StIdle) && bus_io.start && !len_legal;
  assign len_m1    = CntW'(bus_io.len - 4'd1);
  assign cnt_dec   = cnt_q - 1'b1;
  assign gap_load  = (GAP_CYCLES > 0) ? GapW'(GAP_CYCLES - 1) : '0;

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) state_d = StSend;
      end
      StSend: begin
        if (cnt_q == '0) state_d = (GAP_CYCLES == 0) ? StIdle : StGap;
      end
      StGap: begin
        if (gap_q == '0) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs decoded from the current state.
  always_comb begin
    ready = (state_q == StIdle);
  end

  // Datapath next values: the line, valid, pulses and counters are all registered outputs.
  always_comb begin
    sreg_d      = sreg_q;
    cnt_d       = cnt_q;
    gap_d       = gap_q;
    linea_d     = IDLE_LEVEL;
    bit_valid_d = 1'b0;
    done_d      = 1'b0;
    err_d       = reject;
    fcount_d    = fcount_q;

    if (accept) begin
      // The first bit goes out straight from the input so latency to the line is one cycle.
      sreg_d      = bus_io.data;
      cnt_d       = len_m1;
      linea_d     = bus_io.data[len_m1];
      bit_valid_d = 1'b1;
    end

    if (state_q == StSend) begin
      if (cnt_q == '0) begin
        done_d   = 1'b1;
        fcount_d = fcount_q + 8'd1;
        gap_d    = gap_load;
      end else begin
        cnt_d       = cnt_dec;
        linea_d     = sreg_q[cnt_dec];
        bit_valid_d = 1'b1;
      end
    end

    if ((state_q == StGap) && (gap_q != '0)) begin
      gap_d = gap_q - 1'b1;
    end
  end

  // Datapath registers; reset drives the line back to its idle level at once.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sreg_q      <= '0;
      cnt_q       <= '0;
      gap_q       <= '0;
      linea_q     <= IDLE_LEVEL;
      bit_valid_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      fcount_q    <= 8'd0;
    end else begin
      sreg_q      <= sreg_d;
      cnt_q       <= cnt_d;
      gap_q       <= gap_d;
      linea_q     <= linea_d;
      bit_valid_q <= bit_valid_d;
      done_q      <= done_d;
      err_q       <= err_d;
      fcount_q    <= fcount_d;
    end
  end

  assign bus_io.ready       = ready;
  assign bus_io.LINEA       = linea_q;
  assign bus_io.bit_valid   = bit_valid_q;
  assign bus_io.done        = done_q;
  assign bus_io.err         = err_q;
  assign bus_io.frame_count = fcount_q;

endmodule

// File: tb/tb_linea_pattern_tx.sv
// Randomized scoreboard bench for linea_pattern_tx. Two instances: gap of 2 cycles and gap of 0.
// The model turns each accepted request into a timeline of expected line events.
module tb_linea_pattern_tx;

  localparam int MaxLen = 8;

  typedef struct {
    int         kind;  // 0 = frame bit, 1 = done, 2 = err
    logic       bitv;
    logic [7:0] cnt;
    int         due;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic       start_r [2];
  logic [7:0] data_r  [2];
  logic [3:0] len_r   [2];

  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   busy   [2];
  int   mcount [2];
  int   shown  [2];
  int   acc    [2];
  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;

  linea_pattern_tx_if #(.MAX_LEN(8)) if0 ();
  linea_pattern_tx_if #(.MAX_LEN(8)) if1 ();

  assign if0.start = start_r[0];
  assign if0.data  = data_r[0];
  assign if0.len   = len_r[0];
  assign if1.start = start_r[1];
  assign if1.data  = data_r[1];
  assign if1.len   = len_r[1];

  linea_pattern_tx #(.MAX_LEN(8), .GAP_CYCLES(2), .IDLE_LEVEL(1'b0)) dut_g2 (
    .clock  (clk),
    .reset  (rst_n),
    .bus_io (if0)
  );

  linea_pattern_tx #(.MAX_LEN(8), .GAP_CYCLES(0), .IDLE_LEVEL(1'b0)) dut_g0 (
    .clock  (clk),
    .reset  (rst_n),
    .bus_io (if1)
  );

  function automatic int gap_of(input int i);
    return (i == 0) ? 2 : 0;
  endfunction

  function automatic int qsize(input int i);
    return (i == 0) ? q0.size() : q1.size();
  endfunction

  function automatic exp_t qhead(input int i);
    return (i == 0) ? q0[0] : q1[0];
  endfunction

  function automatic exp_t qpop(input int i);
    if (i == 0) return q0.pop_front();
    return q1.pop_front();
  endfunction

  task automatic qpush(input int i, input exp_t e);
    if (i == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic model_reset();
    q0.delete();
    q1.delete();
    for (int i = 0; i < 2; i++) begin
      busy[i]   = 0;
      mcount[i] = 0;
      shown[i]  = 0;
    end
  endtask

  // Reference behaviour at one rising edge: an accepted word becomes a list of timed events.
  task automatic model_edge(input int i);
    int   l;
    exp_t e;
    if (busy[i] > 0) begin
      busy[i]--;
      return;
    end
    if (!start_r[i]) return;
    l = int'(len_r[i]);
    if (l >= 1 && l <= MaxLen) begin
      mcount[i] = (mcount[i] + 1) % 256;
      for (int j = 0; j < l; j++) begin
        e.kind = 0;
        e.bitv = data_r[i][l-1-j];
        e.cnt  = 8'd0;
        e.due  = cyc + j;
        qpush(i, e);
      end
      e.kind = 1;
      e.bitv = 1'b0;
      e.cnt  = 8'(mcount[i]);
      e.due  = cyc + l;
      qpush(i, e);
      busy[i] = l + gap_of(i);
      acc[i]++;
    end else begin
      e.kind = 2;
      e.bitv = 1'b0;
      e.cnt  = 8'd0;
      e.due  = cyc;
      qpush(i, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    if (rst_n) begin
      model_edge(0);
      model_edge(1);
    end
    #1;
  endtask

  task automatic pop_check(input int i, input int kind, input logic [7:0] val);
    exp_t e;
    if (qsize(i) == 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL spurious_output dut%0d: got event kind %0d, required none (cycle %0d)",
               i, kind, cyc);
      return;
    end
    e = qpop(i);
    chk($sformatf("event_kind_dut%0d", i), 32'(kind), 32'(e.kind));
    chk($sformatf("event_cycle_dut%0d", i), 32'(cyc), 32'(e.due));
    if (kind == 0 && e.kind == 0) chk($sformatf("LINEA_bit_dut%0d", i), 32'(val), 32'(e.bitv));
    if (kind == 1 && e.kind == 1) begin
      chk($sformatf("done_count_dut%0d", i), 32'(val), 32'(e.cnt));
      shown[i] = int'(e.cnt);
    end
  endtask

  task automatic mon(input int i, input logic linea, input logic bv, input logic dn,
                     input logic er, input logic rdy, input logic [7:0] fc);
    exp_t e;
    if (!rst_n) begin
      chk($sformatf("rst_LINEA_dut%0d", i), 32'(linea), 32'd0);
      chk($sformatf("rst_bit_valid_dut%0d", i), 32'(bv), 32'd0);
      chk($sformatf("rst_done_dut%0d", i), 32'(dn), 32'd0);
      chk($sformatf("rst_err_dut%0d", i), 32'(er), 32'd0);
      chk($sformatf("rst_frame_count_dut%0d", i), 32'(fc), 32'd0);
      chk($sformatf("rst_ready_dut%0d", i), 32'(rdy), 32'd1);
      return;
    end
    chk($sformatf("ready_dut%0d", i), 32'(rdy), 32'(busy[i] == 0));
    if (bv) pop_check(i, 0, 8'(linea));
    else chk($sformatf("idle_level_dut%0d", i), 32'(linea), 32'd0);
    if (dn) pop_check(i, 1, fc);
    if (er) pop_check(i, 2, 8'd0);
    chk($sformatf("frame_count_dut%0d", i), 32'(fc), 32'(shown[i]));
    for (int n = 0; n < 64; n++) begin
      if (qsize(i) == 0) break;
      e = qhead(i);
      if (e.due > cyc) break;
      e = qpop(i);
      n_vec++;
      n_bad++;
      $display("FAIL missed_event dut%0d: got no output, required kind %0d at cycle %0d",
               i, e.kind, e.due);
    end
  endtask

  // Monitor: samples both instances on the falling edge, away from the active edge.
  always @(negedge clk) begin
    mon(0, if0.LINEA, if0.bit_valid, if0.done, if0.err, if0.ready, if0.frame_count);
    mon(1, if1.LINEA, if1.bit_valid, if1.done, if1.err, if1.ready, if1.frame_count);
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, required finish within time budget");
    $fatal(1, "watchdog");
  end

  task automatic send(input int i, input logic [7:0] d, input logic [3:0] l);
    start_r[i] = 1'b1;
    data_r[i]  = d;
    len_r[i]   = l;
    tick();
    start_r[i] = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    int guard;
    for (int i = 0; i < 2; i++) begin
      start_r[i] = 1'b0;
      data_r[i]  = 8'h00;
      len_r[i]   = 4'd0;
      acc[i]     = 0;
    end
    model_reset();

    // Reset held with a pending legal request.
    start_r[0] = 1'b1;
    len_r[0]   = 4'd3;
    data_r[0]  = 8'hF5;
    idle(3);
    start_r[0] = 1'b0;
    rst_n = 1'b1;
    idle(2);

    // Single frame, then illegal lengths followed by an immediately accepted legal start.
    send(0, 8'hF5, 4'd3);
    idle(8);
    start_r[0] = 1'b1;
    len_r[0]   = 4'd0;
    tick();
    len_r[0]   = 4'd9;
    tick();
    send(0, 8'($urandom), 4'd4);
    idle(10);

    // Start while busy must be ignored.
    send(0, 8'hA5, 4'd8);
    idle(2);
    send(0, 8'h00, 4'd8);
    idle(15);

    // Randomized traffic including illegal lengths and starts while busy.
    for (int c = 0; c < 300; c++) begin
      start_r[0] = ($urandom_range(0, 2) == 0);
      data_r[0]  = 8'($urandom);
      if ($urandom_range(0, 4) == 0) begin
        guard = int'($urandom_range(0, 7));
        len_r[0] = (guard == 0) ? 4'd0 : 4'(8 + guard);
      end else begin
        len_r[0] = 4'($urandom_range(1, 8));
      end
      tick();
    end
    start_r[0] = 1'b0;
    idle(15);

    // Reset in the middle of an 8-bit frame.
    send(0, 8'($urandom), 4'd8);
    idle(2);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("midreset_LINEA", 32'(if0.LINEA), 32'd0);
    chk("midreset_bit_valid", 32'(if0.bit_valid), 32'd0);
    chk("midreset_frame_count", 32'(if0.frame_count), 32'd0);
    idle(2);
    rst_n = 1'b1;
    idle(1);
    send(0, 8'($urandom), 4'd8);
    idle(15);

    // 256 back-to-back one-bit frames with no gap: count wraps through 255 to 0.
    acc[1]     = 0;
    start_r[1] = 1'b1;
    len_r[1]   = 4'd1;
    guard      = 0;
    while (acc[1] < 256 && guard < 2000) begin
      data_r[1] = 8'($urandom);
      tick();
      guard++;
    end
    start_r[1] = 1'b0;
    chk("wrap_frames_accepted", 32'(acc[1]), 32'd256);
    idle(10);
    chk("wrap_frame_count", 32'(if1.frame_count), 32'd0);

    chk("queue_drained_dut0", 32'(qsize(0)), 32'd0);
    chk("queue_drained_dut1", 32'(qsize(1)), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
